// File: rtl/mem_stream_scheduler.sv
// mem_stream_scheduler: issues repeated contiguous RAM read runs and pushes the
// returned words into a downstream FIFO in issue order, throttled by almost_full.
module mem_stream_scheduler #(
    parameter int DATAW      = 8,
    parameter int DEPTH      = 512,
    parameter int ADDRW      = $clog2(DEPTH),
    parameter int LENW       = 16,
    parameter int REPW       = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [LENW-1:0]  length,
    input  logic [REPW-1:0]  reps,
    output logic [ADDRW-1:0] mem_raddr,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             fifo_almost_full,
    output logic             fifo_push,
    output logic [DATAW-1:0] fifo_wdata,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDRW-1:0]      base_q, base_d, raddr_q, raddr_d;
    logic [LENW-1:0]       len_q, len_d, off_q, off_d;
    logic [REPW-1:0]       reps_q, reps_d, pass_q, pass_d;
    logic [RD_LATENCY-1:0] v_q, v_d;
    logic                  done_q, done_d, issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            raddr_q <= '0;
            len_q   <= '0;
            off_q   <= '0;
            reps_q  <= '0;
            pass_q  <= '0;
            v_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            raddr_q <= raddr_d;
            len_q   <= len_d;
            off_q   <= off_d;
            reps_q  <= reps_d;
            pass_q  <= pass_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        raddr_d = raddr_q;
        len_d   = len_q;
        off_d   = off_q;
        reps_d  = reps_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                base_d  = base_addr;
                raddr_d = base_addr;
                len_d   = length;
                reps_d  = (reps == '0) ? REPW'(1) : reps;
                off_d   = '0;
                pass_d  = '0;
                done_d  = (length == '0);
                state_d = (length == '0) ? IDLE : ISSUE;
            end
            ISSUE: begin
                issue = !fifo_almost_full;
                if (issue) begin
                    if (off_q == len_q - 1'b1) begin
                        off_d  = '0;
                        pass_d = pass_q + 1'b1;
                        if (pass_q == reps_q - 1'b1)
                            state_d = DRAIN;
                    end else begin
                        off_d = off_q + 1'b1;
                    end
                    raddr_d = base_q + ADDRW'(off_d);
                end
            end
            default: ;
        endcase
        v_d[0] = issue;
        for (int i = 1; i < RD_LATENCY; i++)
            v_d[i] = v_q[i-1];
        // Leave DRAIN as the last in-flight push lands so done follows it directly.
        if (state_q == DRAIN && v_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        fifo_push  = v_q[RD_LATENCY-1] && !rst;
        fifo_wdata = mem_rdata;
        mem_raddr  = raddr_q;
        done       = done_q;
    end
endmodule
